// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready clients.
// Optional macro ALU_ILLEGAL_CHK_EN: flags ctrl 100/110/111 as illegal and forces a zeroed error response.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic [3:0]        rsp0_flags,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic [3:0]        rsp1_flags,
    output logic              rsp1_err,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_v,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              alu_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_owner;
    logic [WIDTH-1:0]    r_alu_a;
    logic [WIDTH-1:0]    r_alu_b;
    logic [CTRL_W-1:0]   r_alu_ctrl;
    logic                r_rsp0_valid;
    logic [WIDTH-1:0]    r_rsp0_result;
    logic [3:0]          r_rsp0_flags;
    logic                r_rsp0_err;
    logic                r_rsp1_valid;
    logic [WIDTH-1:0]    r_rsp1_result;
    logic [3:0]          r_rsp1_flags;
    logic                r_rsp1_err;

    logic                w_grant;
    logic                w_handshake;
    logic                w_illegal;
    logic                w_owner_ready;
    logic [WIDTH-1:0]    w_cap_result;
    logic [3:0]          w_cap_flags;

    // With both requesting, the one that did not win last time gets the ALU.
    assign w_grant     = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign req0_ready  = (r_state == S_IDLE) && req0_valid && !w_grant;
    assign req1_ready  = (r_state == S_IDLE) && req1_valid && w_grant;
    assign w_handshake = req0_ready || req1_ready;

`ifdef ALU_ILLEGAL_CHK_EN
    assign w_illegal = (r_alu_ctrl == CTRL_W'(3'b100)) ||
                       (r_alu_ctrl == CTRL_W'(3'b110)) ||
                       (r_alu_ctrl == CTRL_W'(3'b111));
`else
    assign w_illegal = 1'b0;
`endif

    assign w_cap_result  = w_illegal ? '0 : alu_result;
    assign w_cap_flags   = w_illegal ? 4'b0000 : {alu_v, alu_c, alu_z, alu_n};
    assign w_owner_ready = r_owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_ctrl    <= '0;
            r_rsp0_valid  <= 1'b0;
            r_rsp0_result <= '0;
            r_rsp0_flags  <= 4'b0000;
            r_rsp0_err    <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp1_result <= '0;
            r_rsp1_flags  <= 4'b0000;
            r_rsp1_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_alu_a      <= w_grant ? req1_a    : req0_a;
                        r_alu_b      <= w_grant ? req1_b    : req0_b;
                        r_alu_ctrl   <= w_grant ? req1_ctrl : req0_ctrl;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= S_EXEC;
                    end
                end
                // The ALU has had a full cycle on the registered operands; capture for the owner.
                S_EXEC: begin
                    if (r_owner) begin
                        r_rsp1_valid  <= 1'b1;
                        r_rsp1_result <= w_cap_result;
                        r_rsp1_flags  <= w_cap_flags;
                        r_rsp1_err    <= w_illegal;
                    end else begin
                        r_rsp0_valid  <= 1'b1;
                        r_rsp0_result <= w_cap_result;
                        r_rsp0_flags  <= w_cap_flags;
                        r_rsp0_err    <= w_illegal;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (w_owner_ready) begin
                        if (r_owner) begin
                            r_rsp1_valid <= 1'b0;
                        end else begin
                            r_rsp0_valid <= 1'b0;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_ctrl;
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp0_result = r_rsp0_result;
    assign rsp0_flags  = r_rsp0_flags;
    assign rsp0_err    = r_rsp0_err;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp1_result = r_rsp1_result;
    assign rsp1_flags  = r_rsp1_flags;
    assign rsp1_err    = r_rsp1_err;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Two-requester arbiter that time-shares one combinational 32-bit ALU (add/sub/and/or/slt, flags v/c/z/n) between two clients, e.g. the R-type execute path and a second unit such as an address or multiply helper.
It uses a valid/ready handshake on request and response channels and round-robin grant. It also registers the operands driven into the ALU and captures the ALU result and flags.
It sits between the clients and the single ALU instance; the ALU stays purely combinational.

Parameters:
WIDTH, 32, operand/result width (ALU is 32-bit; only 32 is supported)
CTRL_W, 3, ALU control width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  operand a
req0_b  in  WIDTH  operand b
req0_ctrl  in  CTRL_W  ALU control (000 add, 001 sub, 010 and, 011 or, 101 slt)
rsp0_valid  out  1  response for requester 0 available
rsp0_ready  in  1  requester 0 takes response
rsp0_result  out  WIDTH  captured ALU result
rsp0_flags  out  4  captured {v,c,z,n}
rsp0_err  out  1  illegal control (see Optional Feature)
req1_valid, req1_ready, req1_a, req1_b, req1_ctrl, rsp1_valid, rsp1_ready, rsp1_result, rsp1_flags, rsp1_err: same as requester 0
alu_a  out  WIDTH  ALU operand a (registered)
alu_b  out  WIDTH  ALU operand b (registered)
alu_control  out  CTRL_W  ALU control (registered)
alu_result  in  WIDTH  ALU result
alu_v, alu_c, alu_z, alu_n  in  1 each  ALU flags

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, last_grant=1 (so requester 0 wins first).
  - owner=0.
  - alu_a/alu_b/alu_control=0.
  - All rsp*_valid/result/flags/err=0; all req*_ready=0 outside IDLE.
- A reset in EXEC or RESP discards the pending operation; no response is ever produced for it.
- States: IDLE, EXEC, RESP.
- IDLE, grant (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - reqX_ready = (state==IDLE) & grant==X & reqX_valid. At most one ready is high.
- IDLE, on handshake:
  - Latch a, b, ctrl into alu_a/alu_b/alu_control.
  - owner=X, last_grant=X, next state EXEC.
- EXEC (exactly 1 cycle):
  - The ALU settles on the registered operands.
  - At the clock edge, capture alu_result and {alu_v,alu_c,alu_z,alu_n} into owner's response regs.
  - Next state RESP.
- RESP:
  - rsp[owner]_valid=1; the other rsp_valid=0.
  - Result/flags/err held stable while valid & !ready.
  - On rsp[owner]_ready: drop valid next cycle, state IDLE.
- Latency: request handshake at edge T, rsp valid from T+2. Minimum 3 cycles per operation; no overlap.
- Flag semantics and the register contents are exactly the ALU's; no re-computation.
- alu_* hold their last values outside EXEC (no toggling).
- A requester that deasserts valid before its handshake loses nothing; no state change.
- Response held indefinitely under backpressure; both req*_ready stay 0 meanwhile.
- Request payload is sampled only at the handshake edge. Later changes to req inputs do not affect the op in flight.

Optional Feature:
Macro ALU_ILLEGAL_CHK_EN.
- Defined: ctrl values 100, 110, 111 are illegal. Such ops are still accepted and still take EXEC (uniform latency). In RESP: err=1, result=0, flags=0000, regardless of ALU output.
- Not defined: rsp*_err is tied 0. Illegal ctrl values pass to the ALU unchanged, and whatever the ALU returns (zero result, z=1) is reported.

Test Plan:
1. After reset, req0 add a=5 b=7 ctrl=000 -> req0_ready at T; alu_a=5, alu_b=7 during EXEC; rsp0_valid from T+2 with result=12, flags v=0 c=0 z=0 n=0; rsp1_valid stays 0.
2. req0 and req1 both valid every cycle, rsp*_ready=1 -> grants 0,1,0,1; each op 3 cycles apart; responses route to the correct owner only.
3. req0 sub 3-3 with rsp0_ready=0 for 4 cycles -> rsp0_valid held 4+ cycles; result=0, z=1, c=1, stable; req1_ready=0 throughout even with req1_valid=1.
4. req1 slt a=0xFFFFFFFF b=1 ctrl=101 -> rsp1_result=1; then req1 or 0xF0 | 0x0F -> result 0xFF.
5. rst pulsed in EXEC of a req1 op -> no rsp1_valid ever; next simultaneous request goes to requester 0.
6. ALU_ILLEGAL_CHK_EN defined, req0 ctrl=110 -> rsp0_err=1, result=0, flags=0000, same 3-cycle latency. Macro undefined -> err=0.
